arp_tx_gen: RTL



---
 rtl/arp_pkg.sv | 69 ++++++
 rtl/arp_tx_gen_if.sv | 43 ++++
 rtl/arp_tx_beat_mux.sv | 47 ++++
 rtl/arp_tx_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arp_pkg
// Description : ARP/Ethernet constants, ARP body layout and frame-image builder
// Revision    : 1.0 - initial release
// ============================================================================
package arp_pkg;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP4 = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ  = 16'h0001;
    localparam logic [15:0] ARP_OPER_REP  = 16'h0002;

    localparam int MAC_W = 48;
    localparam int IP4_W = 32;

    localparam int ARP_FRAME_BYTES     = 42;
    localparam int ARP_FRAME_BYTES_PAD = 60;
    localparam int BEATS_BARE          = 6;
    localparam int BEATS_PAD           = 8;
    localparam logic [7:0] LAST_KEEP_BARE = 8'h03;
    localparam logic [7:0] LAST_KEEP_PAD  = 8'h0F;

    localparam int FRAME_W = ARP_FRAME_BYTES * 8;
    localparam int IMAGE_W = BEATS_PAD * 64;

    typedef struct packed {
        logic [15:0]      htype;
        logic [15:0]      ptype;
        logic [7:0]       hlen;
        logic [7:0]       plen;
        logic [15:0]      oper;
        logic [MAC_W-1:0] sha;
        logic [IP4_W-1:0] spa;
        logic [MAC_W-1:0] tha;
        logic [IP4_W-1:0] tpa;
    } arp_body_t;

    // Returns the 42-byte frame with wire byte k placed at bits [8k+7:8k].
    function automatic logic [FRAME_W-1:0] arp_build_image(
        input logic             is_reply,
        input logic [MAC_W-1:0] tha,
        input logic [IP4_W-1:0] tpa,
        input logic [MAC_W-1:0] sha,
        input logic [IP4_W-1:0] spa
    );
        arp_body_t          body;
        logic [FRAME_W-1:0] wire_order;
        logic [FRAME_W-1:0] img;
        body.htype = ARP_HTYPE_ETH;
        body.ptype = ARP_PTYPE_IP4;
        body.hlen  = 8'h06;
        body.plen  = 8'h04;
        body.oper  = is_reply ? ARP_OPER_REP : ARP_OPER_REQ;
        body.sha   = sha;
        body.spa   = spa;
        body.tha   = is_reply ? tha : '0;
        body.tpa   = tpa;
        wire_order = {(is_reply ? tha : {MAC_W{1'b1}}), sha, ETHERTYPE_ARP, body};
        img = '0;
        for (int k = 0; k < ARP_FRAME_BYTES; k++) begin
            img[8*k +: 8] = wire_order[FRAME_W-1-8*k -: 8];
        end
        return img;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_tx_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : arp_tx_gen_if
// Description : Descriptor, config and AXI Stream bundle of the ARP generator
// Revision    : 1.0 - initial release
// ============================================================================
interface arp_tx_gen_if #(
    parameter int ID_W   = 4,
    parameter int DEST_W = 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_reply;
    logic [47:0]       req_tha;
    logic [31:0]       req_tpa;
    logic [ID_W-1:0]   req_id;
    logic [DEST_W-1:0] req_dest;
    logic [47:0]       cfg_sha;
    logic [31:0]       cfg_spa;
    logic [63:0]       axis_out_tdata;
    logic [7:0]        axis_out_tkeep;
    logic [ID_W-1:0]   axis_out_tid;
    logic [DEST_W-1:0] axis_out_tdest;
    logic              axis_out_tlast;
    logic              axis_out_tvalid;
    logic              axis_out_tready;
    logic [15:0]       tx_frame_count;

    modport master (
        output req_valid, req_is_reply, req_tha, req_tpa, req_id, req_dest,
               cfg_sha, cfg_spa, axis_out_tready,
        input  req_ready, axis_out_tdata, axis_out_tkeep, axis_out_tid,
               axis_out_tdest, axis_out_tlast, axis_out_tvalid, tx_frame_count
    );

    modport slave (
        input  req_valid, req_is_reply, req_tha, req_tpa, req_id, req_dest,
               cfg_sha, cfg_spa, axis_out_tready,
        output req_ready, axis_out_tdata, axis_out_tkeep, axis_out_tid,
               axis_out_tdest, axis_out_tlast, axis_out_tvalid, tx_frame_count
    );
endinterface
`default_nettype wire

// File: rtl/arp_tx_beat_mux.sv
`default_nettype none
// ============================================================================
// Module      : arp_tx_beat_mux
// Description : Selects tdata/tkeep/tlast for one beat of the frame image
// Revision    : 1.0 - initial release
// ============================================================================
module arp_tx_beat_mux
    import arp_pkg::*;
#(
    parameter int PAD_TO_MIN = 1
) (
    input  logic [IMAGE_W-1:0] i_image,
    input  logic [2:0]         i_beat,
    input  logic               i_active,
    output logic [63:0]        o_tdata,
    output logic [7:0]         o_tkeep,
    output logic               o_tlast
);
    logic [2:0] w_last_beat;
    logic [7:0] w_last_keep;
    logic       w_is_last;

    generate
        if (PAD_TO_MIN != 0) begin : g_pad
            assign w_last_beat = 3'(BEATS_PAD - 1);
            assign w_last_keep = LAST_KEEP_PAD;
        end else begin : g_bare
            assign w_last_beat = 3'(BEATS_BARE - 1);
            assign w_last_keep = LAST_KEEP_BARE;
        end
    endgenerate

    assign w_is_last = (i_beat == w_last_beat);

    // Everything is forced to zero outside a frame so idle outputs match reset.
    always_comb begin
        o_tdata = '0;
        o_tkeep = '0;
        o_tlast = 1'b0;
        if (i_active) begin
            o_tdata = i_image[{i_beat, 6'd0} +: 64];
            o_tkeep = w_is_last ? w_last_keep : 8'hFF;
            o_tlast = w_is_last;
        end
    end
endmodule
`default_nettype wire

// File: rtl/arp_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : arp_tx_gen
// Description : Builds one Ethernet II + ARP frame per descriptor onto AXIS
// Revision    : 1.0 - initial release
// ============================================================================
module arp_tx_gen
    import arp_pkg::*;
#(
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 0,
    parameter int PAD_TO_MIN      = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    arp_tx_gen_if.slave bus
);
    localparam int EFF_ID   = (AXIS_ID_WIDTH == 0) ? 1 : AXIS_ID_WIDTH;
    localparam int EFF_DEST = (AXIS_DEST_WIDTH == 0) ? 1 : AXIS_DEST_WIDTH;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_send = 1'b1;

    logic [0:0]          r_state;
    logic                r_req_ready;
    logic [FRAME_W-1:0]  r_image;
    logic [2:0]          r_beat;
    logic [EFF_ID-1:0]   r_tid;
    logic [EFF_DEST-1:0] r_tdest;
    logic [15:0]         r_frame_count;

    logic        w_active;
    logic        w_accept;
    logic [63:0] w_tdata;
    logic [7:0]  w_tkeep;
    logic        w_tlast;

    assign w_active = (r_state == c_st_send);
    assign w_accept = bus.req_valid && r_req_ready;

    arp_tx_beat_mux #(
        .PAD_TO_MIN (PAD_TO_MIN)
    ) u_beat_mux (
        .i_image  ({{(IMAGE_W-FRAME_W){1'b0}}, r_image}),
        .i_beat   (r_beat),
        .i_active (w_active),
        .o_tdata  (w_tdata),
        .o_tkeep  (w_tkeep),
        .o_tlast  (w_tlast)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= c_st_idle;
            r_req_ready   <= 1'b0;
            r_image       <= '0;
            r_beat        <= '0;
            r_tid         <= '0;
            r_tdest       <= '0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_req_ready <= 1'b1;
                    // cfg is captured here so later config writes cannot corrupt the frame
                    if (w_accept) begin
                        r_image     <= arp_build_image(bus.req_is_reply, bus.req_tha,
                                                       bus.req_tpa, bus.cfg_sha, bus.cfg_spa);
                        r_tid       <= bus.req_id;
                        r_tdest     <= bus.req_dest;
                        r_beat      <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (bus.axis_out_tready) begin
                        if (w_tlast) begin
                            r_state       <= c_st_idle;
                            r_req_ready   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.axis_out_tvalid = w_active;
    assign bus.axis_out_tdata  = w_tdata;
    assign bus.axis_out_tkeep  = w_tkeep;
    assign bus.axis_out_tlast  = w_tlast;
    assign bus.axis_out_tid    = r_tid;
    assign bus.axis_out_tdest  = r_tdest;
    assign bus.tx_frame_count  = r_frame_count;
endmodule
`default_nettype wire
